// File: rtl/serial_frame_rx_pkg.sv
// Shared types and constants for the serial frame receiver and its upstream shift-register bench.
// No logic; the sync default and the state encoding live here so both sides agree.
// Backpressure: n/a.
package serial_frame_rx_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'b1001_1001;

    // Ceiling log2; clog2(1) == 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_frame_rx_sipo.sv
// N-bit serial-in parallel-out register, MSB-first, with shift enable and synchronous clear.
// Latency: new bit appears in q[0] the cycle after an enabled edge.
// Backpressure: none; clear takes priority over shift.
module sipo_shift #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         sin,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[N-2:0], sin};
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts an N-bit sync word, then assembles FRAME_WORDS N-bit payload words.
// Latency: a word is presented on dout one cycle after the edge sampling its last bit.
// Backpressure: valid/ready; a word completing while dout is held unaccepted is dropped and sets overflow.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int             N           = 8,
    parameter logic [N-1:0]   SYNC        = N'(SYNC_DEFAULT),
    parameter int             FRAME_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sin,
    input  logic                          sin_en,
    output logic [N-1:0]                  dout,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic                          locked,
    output logic                          frame_end,
    output logic                          overflow,
    input  logic                          clr_ovf,
    output logic [clog2(FRAME_WORDS):0]   word_idx
);

    localparam int BCW = clog2(N);
    localparam int HCW = clog2(N + 1);
    localparam int WIW = clog2(FRAME_WORDS) + 1;

    state_t         state, state_nxt;
    logic [BCW-1:0] bit_cnt, bit_cnt_nxt;
    logic [HCW-1:0] hunt_cnt, hunt_cnt_nxt;
    logic [WIW-1:0] word_idx_nxt;
    logic           frame_end_nxt;
    logic [N-1:0]   shift_q;
    logic [N-1:0]   shift_nxt;
    logic           shift_clr;
    logic           word_done;
    logic           load_ok;

    // One register serves as the sync window in HUNT and the word assembler in PAYLOAD:
    // after N payload bits it holds exactly the payload word, whatever it held before.
    sipo_shift #(.N(N)) u_shift (
        .clk   (clk),
        .reset (reset),
        .en    (sin_en),
        .clr   (shift_clr),
        .sin   (sin),
        .q     (shift_q)
    );

    assign shift_nxt = {shift_q[N-2:0], sin};
    assign load_ok   = !dout_valid || dout_ready;
    assign locked    = (state == PAYLOAD);

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        hunt_cnt_nxt  = hunt_cnt;
        word_idx_nxt  = word_idx;
        frame_end_nxt = 1'b0;
        shift_clr     = 1'b0;
        word_done     = 1'b0;
        case (state)
            HUNT: begin
                word_idx_nxt = '0;
                if (sin_en) begin
                    if (hunt_cnt != HCW'(N)) begin
                        hunt_cnt_nxt = hunt_cnt + 1'b1;
                    end
                    // hunt_cnt saturates at N, so reaching N means at least N fresh bits.
                    if (shift_nxt == SYNC && hunt_cnt_nxt == HCW'(N)) begin
                        state_nxt   = PAYLOAD;
                        bit_cnt_nxt = '0;
                    end
                end
            end
            PAYLOAD: begin
                if (sin_en) begin
                    if (bit_cnt == BCW'(N - 1)) begin
                        word_done    = 1'b1;
                        bit_cnt_nxt  = '0;
                        word_idx_nxt = word_idx + 1'b1;
                        if (word_idx == WIW'(FRAME_WORDS - 1)) begin
                            frame_end_nxt = 1'b1;
                            state_nxt     = HUNT;
                            shift_clr     = 1'b1;
                            hunt_cnt_nxt  = '0;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            bit_cnt   <= '0;
            hunt_cnt  <= '0;
            word_idx  <= '0;
            frame_end <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            hunt_cnt  <= hunt_cnt_nxt;
            word_idx  <= word_idx_nxt;
            frame_end <= frame_end_nxt;
        end
    end

    // Output holding register: a drop leaves dout untouched and only raises overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (word_done && load_ok) begin
                dout       <= shift_nxt;
                dout_valid <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (word_done && !load_ok) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (N=8, FRAME_WORDS=2) against a bit-level behavioural model.
module tb_serial_frame_rx;
    import serial_frame_rx_pkg::*;

    localparam int N  = 8;
    localparam int FW = 2;
    localparam logic [7:0] SYNC = SYNC_DEFAULT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sin = 1'b0;
    logic       sin_en = 1'b0;
    logic       dout_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       locked;
    logic       frame_end;
    logic       overflow;
    logic [1:0] word_idx;

    always #5 clk = ~clk;

    serial_frame_rx #(.N(N), .SYNC(SYNC), .FRAME_WORDS(FW)) dut (
        .clk        (clk),
        .reset      (reset),
        .sin        (sin),
        .sin_en     (sin_en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .locked     (locked),
        .frame_end  (frame_end),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .word_idx   (word_idx)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: the receiver as a bit history plus a word list.
    int   m_win = 0, m_nb = 0, m_pay = 0, m_pb = 0, m_words = 0, m_word = 0;
    bit   m_hunt = 1'b1, m_done, m_drop;
    int   e_dout = 0, e_widx = 0;
    bit   e_valid = 0, e_fe = 0, e_ovf = 0, e_locked = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hunt = 1'b1; m_win = 0; m_nb = 0; m_pay = 0; m_pb = 0; m_words = 0;
            e_dout = 0; e_widx = 0; e_valid = 0; e_fe = 0; e_ovf = 0; e_locked = 0;
        end else begin
            m_done = 1'b0;
            e_fe   = 1'b0;
            if (m_hunt) e_widx = 0;
            if (sin_en) begin
                if (m_hunt) begin
                    m_win = ((m_win << 1) | int'(sin)) & 'hFF;
                    m_nb++;
                    if (m_win == int'(SYNC) && m_nb >= N) begin
                        m_hunt = 1'b0; m_pb = 0; m_words = 0;
                    end
                end else begin
                    m_pay = ((m_pay << 1) | int'(sin)) & 'hFF;
                    m_pb++;
                    if (m_pb == N) begin
                        m_done = 1'b1; m_word = m_pay; m_pb = 0;
                        m_words++;
                        e_widx = m_words;
                        if (m_words == FW) begin
                            e_fe = 1'b1; m_hunt = 1'b1; m_win = 0; m_nb = 0;
                        end
                    end
                end
            end
            m_drop = m_done && e_valid && !dout_ready;
            if (m_done && !m_drop) begin
                e_dout = m_word; e_valid = 1'b1;
            end else if (e_valid && dout_ready) begin
                e_valid = 1'b0;
            end
            if (m_drop) e_ovf = 1'b1;
            else if (clr_ovf) e_ovf = 1'b0;
            e_locked = !m_hunt;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #2;
        chk("dout", dout, e_dout);
        chk("dout_valid", dout_valid, e_valid);
        chk("locked", locked, e_locked);
        chk("frame_end", frame_end, e_fe);
        chk("overflow", overflow, e_ovf);
        chk("word_idx", word_idx, e_widx);
    end

    logic [7:0] acc_q[$];
    always @(negedge clk) begin
        #4;
        if (!reset && dout_valid && dout_ready) acc_q.push_back(dout);
    end

    task automatic send_bit(input logic b, input logic en);
        @(negedge clk);
        sin = b;
        sin_en = en;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gap);
        for (int i = 7; i >= 0; i--) begin
            if (gap) send_bit(~v[i], 1'b0);
            send_bit(v[i], 1'b1);
        end
    endtask

    // All bits but the last; caller sends bit 0 so it can pair it with other inputs.
    task automatic send_top7(input logic [7:0] v);
        for (int i = 7; i >= 1; i--) send_bit(v[i], 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) send_bit(1'b0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    int t0;
    logic [7:0] exp_words[14];

    initial begin
        exp_words = '{8'hA5, 8'h0F, 8'h3C, 8'h81, 8'hA5, 8'h0F, 8'h11, 8'h33,
                      8'hE7, 8'h18, 8'h5A, 8'hC3, 8'h96, 8'h69};
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_frame_end", frame_end, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_word_idx", word_idx, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Clean frame
        dout_ready = 1'b1;
        send_byte(SYNC, 0);
        after_edge(); chk("clean_lock", locked, 1);
        send_byte(8'hA5, 0);
        after_edge(); chk("clean_w0", dout, 8'hA5); chk("clean_w0_vld", dout_valid, 1);
        send_byte(8'h0F, 0);
        after_edge(); chk("clean_w1", dout, 8'h0F); chk("clean_fe", frame_end, 1);
        chk("clean_unlock", locked, 0); chk("clean_widx", word_idx, 2);
        idle(3);

        // Sync after noise
        send_bit(1, 1); send_bit(1, 1); send_bit(0, 1);
        send_byte(SYNC, 0);
        after_edge(); chk("noise_lock", locked, 1);
        send_byte(8'h3C, 0);
        after_edge(); chk("noise_w0", dout, 8'h3C);
        send_byte(8'h81, 0);
        idle(3);

        // sin_en gaps
        send_byte(SYNC, 1);
        after_edge(); chk("gap_lock", locked, 1);
        send_byte(8'hA5, 1);
        after_edge(); chk("gap_w0", dout, 8'hA5); chk("gap_w0_vld", dout_valid, 1);
        send_byte(8'h0F, 1);
        after_edge(); chk("gap_w1", dout, 8'h0F); chk("gap_fe", frame_end, 1);
        idle(3);

        // Backpressure: 22 dropped, then clear
        dout_ready = 1'b0;
        send_byte(SYNC, 0);
        send_byte(8'h11, 0);
        after_edge(); chk("bp_w0", dout, 8'h11); chk("bp_ovf0", overflow, 0);
        send_byte(8'h22, 0);
        after_edge(); chk("bp_ovf1", overflow, 1); chk("bp_hold", dout, 8'h11);
        chk("bp_hold_vld", dout_valid, 1);
        @(negedge clk); sin_en = 1'b0; clr_ovf = 1'b1;
        after_edge(); chk("bp_clr", overflow, 0);
        @(negedge clk); clr_ovf = 1'b0;
        idle(2);

        // Accept + load on one edge, then drop colliding with clr_ovf
        send_byte(SYNC, 0);
        send_top7(8'h33);
        send_bit(1'b1, 1'b1); dout_ready = 1'b1;
        after_edge(); chk("swap_w", dout, 8'h33); chk("swap_vld", dout_valid, 1);
        dout_ready = 1'b0;
        send_top7(8'h44);
        send_bit(1'b0, 1'b1); clr_ovf = 1'b1;
        after_edge(); chk("drop_wins", overflow, 1); chk("drop_hold", dout, 8'h33);
        @(negedge clk); clr_ovf = 1'b0; sin_en = 1'b0; dout_ready = 1'b1;
        after_edge(); chk("bp_drain", dout_valid, 0);
        @(negedge clk); clr_ovf = 1'b1;
        after_edge(); chk("bp_clr2", overflow, 0);
        @(negedge clk); clr_ovf = 1'b0;
        idle(2);

        // Reset mid-frame
        send_byte(SYNC, 0);
        send_bit(0, 1); send_bit(1, 1); send_bit(0, 1);
        after_edge(); chk("mid_lock", locked, 1);
        @(negedge clk); sin_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("arst_locked", locked, 0);
        chk("arst_widx", word_idx, 0);
        chk("arst_valid", dout_valid, 0);
        chk("arst_dout", dout, 0);
        @(negedge clk); reset = 1'b0;
        send_bit(1, 1); send_bit(0, 1); send_bit(1, 1); send_bit(0, 1); send_bit(1, 1);
        send_byte(8'hA5, 0);
        send_byte(8'h0F, 0);
        after_edge(); chk("post_rst_nolock", locked, 0); chk("post_rst_novld", dout_valid, 0);
        send_byte(SYNC, 0);
        after_edge(); chk("post_rst_lock", locked, 1);
        send_byte(8'hE7, 0);
        send_byte(8'h18, 0);
        idle(3);

        // Back-to-back frames
        send_byte(SYNC, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hC3, 0);
        after_edge(); chk("b2b_fe", frame_end, 1); chk("b2b_widx_end", word_idx, 2);
        t0 = cyc;
        send_byte(SYNC, 0);
        after_edge(); chk("b2b_lock", locked, 1); chk("b2b_widx0", word_idx, 0);
        chk("b2b_lock_dist", cyc - t0, N);
        send_byte(8'h96, 0);
        send_byte(8'h69, 0);
        after_edge(); chk("b2b_fe2", frame_end, 1);
        idle(4);

        chk("accepted_count", acc_q.size(), 14);
        for (int i = 0; i < 14; i++) begin
            if (i < acc_q.size()) chk("accepted_word", acc_q[i], exp_words[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Serial-to-parallel frame receiver. Sits directly downstream of the shift register stage and consumes its serial output bit (sout) one bit per qualified clock.
- Hunts for an N-bit sync word, then assembles FRAME_WORDS payload words of N bits each.
- Presents each word on a valid/ready parallel interface. Flags words dropped for lack of ready.

Parameters:
- N, 8, word width and sync width in bits (N >= 2)
- SYNC, 8'b1001_1001, sync pattern, N bits wide
- FRAME_WORDS, 4, payload words per frame after sync (>= 1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- sin  input  1  serial data bit (upstream sout)
- sin_en  input  1  sin is sampled only on edges where sin_en=1
- dout  output  N  assembled payload word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout on an edge with valid&&ready
- locked  output  1  high while in PAYLOAD state
- frame_end  output  1  one-cycle pulse after the last payload word of a frame is assembled
- overflow  output  1  sticky: a completed word was dropped
- clr_ovf  input  1  synchronous clear of overflow
- word_idx  output  clog2(FRAME_WORDS)+1  payload words assembled in the current frame

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset values: dout=0, dout_valid=0, locked=0, frame_end=0, overflow=0, word_idx=0. Internal state: window=0, bit counters=0, state=HUNT.
- Bit order is MSB-first. On each sin_en edge the shift reg takes {shift[N-2:0], sin}, so the first received bit lands in dout[N-1].
- Edges with sin_en=0 change nothing except the handshake, frame_end, and clr_ovf effects.
- HUNT state:
  - Shifts sin into window.
  - A saturating counter hunt_cnt counts bits since entering HUNT.
  - Sync hit: after the sin_en edge, the updated window==SYNC and hunt_cnt >= N (including this bit).
  - On a sync hit: go to PAYLOAD on that edge, clear bit_cnt, set word_idx=0. locked reads 1 from the next cycle.
  - Overlapping patterns are allowed; the check runs every bit.
- PAYLOAD state:
  - bit_cnt counts 0..N-1. When the Nth bit is sampled the word is complete; bit_cnt wraps to 0.
  - word_idx increments on each complete word.
- Word delivery:
  - A completed word is registered. dout/dout_valid update on the same edge as the last bit, so they are visible the cycle after that edge (1-cycle latency).
  - Load is allowed if dout_valid=0, or if dout_valid&&dout_ready on the same edge. In that case dout_valid stays 1 with the new word.
  - Otherwise the word is dropped, overflow is set, and dout is unchanged.
- Handshake: dout and dout_valid are stable while dout_valid && !dout_ready. Accept clears dout_valid unless a new word loads on the same edge.
- End of frame:
  - When word_idx reaches FRAME_WORDS: frame_end pulses for 1 cycle and the state returns to HUNT.
  - Returning to HUNT clears window, hunt_cnt, bit_cnt and word_idx. dout/dout_valid are left pending.
  - The next sync requires N fresh bits.
- overflow:
  - Stays set until clr_ovf.
  - If clr_ovf and a new drop occur on the same edge, the drop wins and overflow stays 1.
- Reset mid-frame: immediately returns to reset values. A pending word is discarded.
- Free-running: no timeout in HUNT.

Decomposition:
- Shared package holds:
  - State enum: HUNT, PAYLOAD.
  - Default SYNC constant 8'b1001_1001, shared with the upstream shift-register bench.
  - A clog2 helper function.
- One sub-module is natural: sipo_shift, an N-bit serial-in parallel-out register with shift enable and synchronous clear. It is instantiated for the sync window and reused for payload assembly.
- The FSM, counters and handshake stay in the top module.

Test Plan:
- Clean frame, N=8, FRAME_WORDS=2, dout_ready=1, sin_en=1: send bits 10011001, 10100101, 00001111.
  - locked=1 the cycle after the 8th bit.
  - dout=8'hA5 then 8'h0F, each with a 1-cycle valid.
  - frame_end pulse after 8'h0F; locked=0.
- Sync after noise: send 1,1,0 then 10011001 then a payload of 8'h3C.
  - No lock during the noise bits; lock after the full SYNC.
  - dout=8'h3C.
- sin_en gaps: same frame as the clean-frame case, with sin_en toggling 1/0 every cycle.
  - Identical words 8'hA5 and 8'h0F.
  - Latency counted in sin_en edges; nothing changes on sin_en=0 edges.
- Backpressure: dout_ready=0 across two words 8'h11 and 8'h22.
  - dout holds 8'h11 with valid=1; overflow=1 at completion of 8'h22.
  - Then assert clr_ovf: overflow=0 next cycle.
  - Also check a simultaneous accept + new word: dout switches to the new word with valid held 1.
- Reset mid-frame: assert reset after 3 payload bits.
  - All outputs 0 asynchronously, without waiting for a clk edge.
  - After release, the payload stream alone does not lock; a fresh SYNC is required.
- Back-to-back frames: two consecutive frames, with SYNC immediately following the last payload word.
  - Second lock occurs exactly N bits after frame_end.
  - word_idx restarts at 0.
